// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (receiver FSM states, frame width,
// bit-period counter width). Imported by uart_rx, uart_rx_sync and uart_tx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_DELAY_MIN = 4;
    localparam int UART_DELAY_W   = 12;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } uart_state_t;

    // 2-of-3 vote used by the optional receive noise filter.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: metastability synchroniser for the asynchronous rx line.
// rx_s is the line after SYNC_STAGES flops. rx_bit is the value the FSM
// samples. With UART_RX_MAJORITY_EN defined, rx_bit is the 2-of-3 vote of
// rx_s over the current and two previous cycles, so the vote taken at
// timer == 0 covers timer == 2, 1, 0. Otherwise rx_bit is rx_s.
import uart_pkg::*;

module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_bit
);

    logic [SYNC_STAGES-1:0] chain;

    // Synchroniser chain; it resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (!reset_n) chain <= '1;
        else          chain <= {chain[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = chain[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Two-cycle history of rx_s that feeds the 3-tap vote.
    always_ff @(posedge clock) begin
        if (!reset_n) hist <= '1;
        else          hist <= {hist[0], rx_s};
    end

    assign rx_bit = maj3(rx_s, hist[0], hist[1]);
`else
    assign rx_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 / 8O1 UART receiver, LSB first, bit period = delay clocks.
// Samples are taken at mid-bit by a down-counter that is loaded with delay>>1
// on the start edge. The module delivers each byte with a one-cycle valid
// pulse plus parity and framing error flags.
// Optional build macro: UART_RX_MAJORITY_EN (3-tap majority sampling,
// which needs delay >= 6).
import uart_pkg::*;

module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [UART_DELAY_W-1:0] delay,
    input  logic                    parity,
    input  logic                    rx,
    output logic [7:0]              out,
    output logic                    valid,
    output logic                    perr,
    output logic                    ferr,
    output logic                    busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t             state, state_next;
    logic [UART_DELAY_W-1:0] timer;
    logic [2:0]              count;
    logic [7:0]              shreg;
    logic                    pbit;
    logic                    rx_s;
    logic                    rx_bit;
    logic                    sample;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_bit  (rx_bit)
    );

    assign sample = (timer == '0);
    assign busy   = (state != IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic. The start edge uses the raw synchronised line, and
    // every mid-bit decision uses the sampled bit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!rx_s)  state_next = START;
            START:   if (sample) state_next = rx_bit ? IDLE : DATA;
            DATA:    if (sample && count == LAST_BIT)
                         state_next = parity ? PAR : STOP;
            PAR:     if (sample) state_next = STOP;
            STOP:    if (sample) state_next = rx_bit ? IDLE : BRK;
            BRK:     if (rx_s)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit timer: loaded with half a period while idle, so the first
    // expiry lands mid start bit. It then reloads so that samples are
    // exactly delay clocks apart.
    always_ff @(posedge clock) begin
        if (state == IDLE) timer <= delay >> 1;
        else if (sample)   timer <= delay - 1'b1;
        else               timer <= timer - 1'b1;
    end

    // Data path: bit counter, LSB-first shift register and parity capture.
    always_ff @(posedge clock) begin
        if (sample) begin
            case (state)
                START: count <= '0;
                DATA: begin
                    shreg <= {rx_bit, shreg[7:1]};
                    count <= count + 1'b1;
                end
                PAR:   pbit <= rx_bit;
                default: ;
            endcase
        end
    end

    // Frame delivery at mid stop bit. out is written even when an error
    // flag is set, and the flags hold until the next frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out   <= '0;
            valid <= 1'b0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == STOP && sample) begin
                out   <= shreg;
                perr  <= parity & ~(^{shreg, pbit});
                ferr  <= ~rx_bit;
                valid <= 1'b1;
            end
        end
    end

endmodule
